regfile_psr: RTL and testbench
==============================

REGFILE_PSR -- requirements
Module: regfile_psr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of every register.
REQ-002 The block SHALL have parameter NREGS, default 16, giving the register count, addressed by 4 bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: register write strobe.
REQ-006 The block SHALL have port wr_addr, input, 4 bits: write register index.
REQ-007 The block SHALL have port wr_data, input, WIDTH bits: write value, normally the ALU Out.
REQ-008 The block SHALL have port rd_addr_src, input, 4 bits: source-operand read index.
REQ-009 The block SHALL have port rd_addr_dest, input, 4 bits: destination-operand read index.
REQ-010 The block SHALL have port rsrc, output, WIDTH bits: registered source operand, feeding ALU Rsrc.
REQ-011 The block SHALL have port rdest, output, WIDTH bits: registered destination operand, feeding ALU Rdest.
REQ-012 The block SHALL have port flags_in, input, 5 bits: ALU flags, bit order [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
REQ-013 The block SHALL have port flag_en, input, 5 bits: per-bit PSR update mask, same bit order as flags_in.
REQ-014 The block SHALL have port psr, output, 5 bits: current processor status flags.
REQ-015 The block SHALL have port cond, input, 4 bits: branch condition code.
REQ-016 The block SHALL have port cond_true, output, 1 bit: the condition evaluated against psr.

Function
REQ-017 Writes SHALL take effect at the rising clk edge when wr_en=1: reg[wr_addr] <= wr_data.
REQ-018 Reads SHALL be synchronous with 1-cycle latency: rsrc <= reg[rd_addr_src] and rdest <= reg[rd_addr_dest] on every edge.
REQ-019 Write-through bypass: when wr_en=1 and a read address equals wr_addr in the same cycle, the corresponding output SHALL load wr_data, not the old contents.
REQ-020 If both read addresses equal wr_addr, both outputs SHALL receive wr_data.
REQ-021 At each edge, for each bit i with flag_en[i]=1, psr[i] SHALL load flags_in[i]; bits with flag_en[i]=0 SHALL hold their value.
REQ-022 flag_en=5'b00000 SHALL leave psr unchanged.
REQ-023 cond_true SHALL be combinational from the registered psr only; a flag update becomes visible to cond_true the cycle after its edge, with no bypass.
REQ-024 cond encoding SHALL be:
- 0 EQ: Z=1
- 1 NE: Z=0
- 2 CS: C=1
- 3 CC: C=0
- 4 HI: L=1
- 5 LS: L=0
- 6 GT: N=1
- 7 LE: N=0
- 8 FS: F=1
- 9 FC: F=0
- 10 LO: L=0 and Z=0
- 11 HS: L=1 or Z=1
- 12 LT: N=0 and Z=0
- 13 GE: N=1 or Z=1
- 14 UC: always 1
- 15: always 0
REQ-025 Register writes and PSR updates in the same cycle SHALL be independent; both SHALL complete.
REQ-026 The block SHALL contain no combinational path from wr_data or flags_in to any output.

Reset
REQ-027 When reset=1 at an edge, all NREGS registers, rsrc, rdest and psr SHALL become 0, regardless of wr_en and flag_en.
REQ-028 While reset=1, any write or flag update presented SHALL be discarded.
REQ-029 The first write SHALL be accepted on the first edge with reset=0.
REQ-030 Immediately after reset, cond_true SHALL be 1 for codes 1, 3, 5, 7, 9, 10, 12 and 14, and 0 for all other codes.

Verification
REQ-031 Reset, then write 0x1234 to r3, next cycle read src=r3 -> rsrc=0x1234 one cycle later.
REQ-032 In the same cycle, wr_en=1, wr_addr=5, wr_data=0xBEEF, rd_addr_src=rd_addr_dest=5 -> rsrc=rdest=0xBEEF after the edge.
REQ-033 With psr=0, flags_in=5'b11111 and flag_en=5'b01001 -> psr=5'b01001; next cycle cond=0 (EQ) -> cond_true=1, and cond=8 (FS) -> 0.
REQ-034 Write r7=0xFFFF with reset=1 in the same cycle -> r7 reads 0 after reset is released.
REQ-035 Sweep all 16 cond codes against all 32 psr values -> cond_true matches REQ-024 in every case.
REQ-036 Back-to-back writes of 0x0001 then 0x0002 to r2, reading r2 in each cycle -> rsrc=0x0001, then 0x0002.

Source files
------------

// File: rtl/regfile_psr.sv
// Register file with synchronous dual read ports, write-through bypass, and a
// maskable processor status register driving a branch-condition evaluator.
module regfile_psr #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       rd_addr_src,
    input  logic [3:0]       rd_addr_dest,
    output logic [WIDTH-1:0] rsrc,
    output logic [WIDTH-1:0] rdest,
    input  logic [4:0]       flags_in,
    input  logic [4:0]       flag_en,
    output logic [4:0]       psr,
    input  logic [3:0]       cond,
    output logic             cond_true
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] rsrc_q, rsrc_d;
    logic [WIDTH-1:0] rdest_q, rdest_d;
    logic [4:0]       psr_q, psr_d;
    logic             wr_hit;

    // Writes to indices beyond NREGS are dropped and never bypassed.
    assign wr_hit = wr_en && (32'(wr_addr) < NREGS);

    always_comb begin
        regs_d  = regs_q;
        rsrc_d  = '0;
        rdest_d = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (wr_hit && wr_addr == 4'(i)) begin
                regs_d[i] = wr_data;
            end
            if (rd_addr_src == 4'(i)) begin
                rsrc_d = regs_q[i];
            end
            if (rd_addr_dest == 4'(i)) begin
                rdest_d = regs_q[i];
            end
        end
        if (wr_hit && rd_addr_src == wr_addr) begin
            rsrc_d = wr_data;
        end
        if (wr_hit && rd_addr_dest == wr_addr) begin
            rdest_d = wr_data;
        end
        psr_d = (psr_q & ~flag_en) | (flags_in & flag_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            rsrc_q  <= '0;
            rdest_q <= '0;
            psr_q   <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
            rsrc_q  <= rsrc_d;
            rdest_q <= rdest_d;
            psr_q   <= psr_d;
        end
    end

    assign rsrc  = rsrc_q;
    assign rdest = rdest_q;
    assign psr   = psr_q;

    // PSR bit order: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:    cond_true = psr_q[3];
            4'd1:    cond_true = !psr_q[3];
            4'd2:    cond_true = psr_q[0];
            4'd3:    cond_true = !psr_q[0];
            4'd4:    cond_true = psr_q[1];
            4'd5:    cond_true = !psr_q[1];
            4'd6:    cond_true = psr_q[4];
            4'd7:    cond_true = !psr_q[4];
            4'd8:    cond_true = psr_q[2];
            4'd9:    cond_true = !psr_q[2];
            4'd10:   cond_true = !psr_q[1] && !psr_q[3];
            4'd11:   cond_true = psr_q[1] || psr_q[3];
            4'd12:   cond_true = !psr_q[4] && !psr_q[3];
            4'd13:   cond_true = psr_q[4] || psr_q[3];
            4'd14:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_regfile_psr.sv
// Randomized and directed bench for regfile_psr against a behavioural model of
// the register array, status flags and condition table.
module tb_regfile_psr;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset, wr_en;
    logic [3:0]       wr_addr, rd_addr_src, rd_addr_dest, cond;
    logic [WIDTH-1:0] wr_data, rsrc, rdest;
    logic [4:0]       flags_in, flag_en, psr;
    logic             cond_true;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] m_regs [16];
    logic [WIDTH-1:0] m_src, m_dest;
    logic [4:0]       m_psr;

    regfile_psr #(.WIDTH(WIDTH), .NREGS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr_src  (rd_addr_src),
        .rd_addr_dest (rd_addr_dest),
        .rsrc         (rsrc),
        .rdest        (rdest),
        .flags_in     (flags_in),
        .flag_en      (flag_en),
        .psr          (psr),
        .cond         (cond),
        .cond_true    (cond_true)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_ref(input logic [3:0] c, input logic [4:0] p);
        logic fc, fl, ff, fz, fn;
        {fn, fz, ff, fl, fc} = p;
        case (c)
            0:  return fz;
            1:  return !fz;
            2:  return fc;
            3:  return !fc;
            4:  return fl;
            5:  return !fl;
            6:  return fn;
            7:  return !fn;
            8:  return ff;
            9:  return !ff;
            10: return !fl && !fz;
            11: return fl || fz;
            12: return !fn && !fz;
            13: return fn || fz;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, check all outputs.
    task automatic cycle(input logic rst, input logic we, input logic [3:0] wa,
                         input logic [WIDTH-1:0] wd, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [4:0] fi, input logic [4:0] fe, input logic [3:0] c);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_src = ra; rd_addr_dest = rb; flags_in = fi; flag_en = fe; cond = c;
        @(posedge clk);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_src = '0; m_dest = '0; m_psr = '0;
        end else begin
            m_src  = (we && wa == ra) ? wd : m_regs[ra];
            m_dest = (we && wa == rb) ? wd : m_regs[rb];
            if (we) m_regs[wa] = wd;
            for (int i = 0; i < 5; i++) if (fe[i]) m_psr[i] = fi[i];
        end
        #1;
        check("rsrc", 32'(rsrc), 32'(m_src));
        check("rdest", 32'(rdest), 32'(m_dest));
        check("psr", 32'(psr), 32'(m_psr));
        check("cond_true", 32'(cond_true), 32'(cond_ref(c, m_psr)));
    endtask

    initial begin
        logic [15:0] after_reset;
        after_reset = 16'h56AA;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_src = '0; rd_addr_dest = '0; flags_in = '0; flag_en = '0; cond = '0;

        // Reset state and condition table with psr=0.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_rsrc", 32'(rsrc), 0);
        check("reset_psr", 32'(psr), 0);
        for (int c = 0; c < 16; c++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 4'(c));
            check("reset_cond", 32'(cond_true), 32'(after_reset[c]));
        end

        // First write after reset, then read.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 3, 16'h1234, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 3, 0, 0, 0, 0);
        check("rd_r3", 32'(rsrc), 32'h1234);

        // Bypass to both ports.
        cycle(0, 1, 5, 16'hBEEF, 5, 5, 0, 0, 0);
        check("byp_src", 32'(rsrc), 32'hBEEF);
        check("byp_dest", 32'(rdest), 32'hBEEF);

        // Masked flag update.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 5'b11111, 5'b01001, 0);
        check("psr_mask", 32'(psr), 32'b01001);
        check("cond_eq", 32'(cond_true), 1);
        cycle(0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 8);
        check("psr_hold", 32'(psr), 32'b01001);
        check("cond_fs", 32'(cond_true), 0);

        // Write under reset is discarded.
        cycle(1, 1, 7, 16'hFFFF, 0, 0, 5'b11111, 5'b11111, 0);
        cycle(0, 0, 0, 0, 7, 7, 0, 0, 0);
        check("rst_wr_r7", 32'(rsrc), 0);
        check("rst_psr", 32'(psr), 0);

        // Back-to-back writes with same-cycle reads.
        cycle(0, 1, 2, 16'h0001, 2, 0, 0, 0, 0);
        check("b2b_1", 32'(rsrc), 32'h0001);
        cycle(0, 1, 2, 16'h0002, 2, 0, 0, 0, 0);
        check("b2b_2", 32'(rsrc), 32'h0002);

        // Full condition sweep over every psr value.
        for (int p = 0; p < 32; p++) begin
            cycle(0, 0, 0, 0, 0, 0, 5'(p), 5'b11111, 0);
            for (int c = 0; c < 16; c++) begin
                cycle(0, 0, 0, 0, 0, 0, 0, 0, 4'(c));
            end
        end

        // Random traffic, including simultaneous register and flag updates.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(31) == 0), 1'($urandom), 4'($urandom), 16'($urandom),
                  4'($urandom), 4'($urandom), 5'($urandom), 5'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
